// File: rtl/or1k_ctrl_lsu_cappuccino.sv
// Ctrl-stage load/store responder: runs one data-bus transaction per op and
// returns the extended load result, valid, exception flags and msync stall.
module or1k_ctrl_lsu_cappuccino #(
    parameter int OPTION_OPERAND_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_ctrl_i,
    input  logic                            pipeline_flush_i,
    input  logic                            ctrl_op_lsu_load_i,
    input  logic                            ctrl_op_lsu_store_i,
    input  logic [1:0]                      ctrl_lsu_length_i,
    input  logic                            ctrl_lsu_zext_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_lsu_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_rfb_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] dbus_adr_o,
    output logic                            dbus_req_o,
    output logic                            dbus_we_o,
    output logic [3:0]                      dbus_bsel_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_o,
    input  logic                            dbus_ack_i,
    input  logic                            dbus_err_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] lsu_result_o,
    output logic                            lsu_valid_o,
    output logic                            lsu_except_align_o,
    output logic                            lsu_except_dbus_o,
    output logic                            msync_stall_o
);

    // state  | meaning
    // IDLE   | waiting for an op
    // ACCESS | bus request outstanding, result will be returned
    // DRAIN  | flushed while outstanding; wait for ack/err and discard
    // DONE   | result valid until the ctrl stage advances or flushes
    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic                            op;
    logic                            misaligned;
    logic                            start;
    logic [3:0]                      bsel_next;
    logic [OPTION_OPERAND_WIDTH-1:0] dat_next;
    logic [OPTION_OPERAND_WIDTH-1:0] load_data;
    logic [1:0]                      lsb_r;
    logic [1:0]                      len_r;
    logic                            zext_r;

    assign op    = ctrl_op_lsu_load_i | ctrl_op_lsu_store_i;
    assign start = (state == IDLE) && op && !pipeline_flush_i &&
                   !lsu_except_align_o && !lsu_except_dbus_o;

    always_comb begin
        misaligned = 1'b0;
        bsel_next  = 4'b1111;
        dat_next   = ctrl_rfb_i;
        case (ctrl_lsu_length_i)
            2'b00: begin
                bsel_next = 4'b1000 >> ctrl_lsu_adr_i[1:0];
                dat_next  = {4{ctrl_rfb_i[7:0]}};
            end
            2'b01: begin
                misaligned = ctrl_lsu_adr_i[0];
                bsel_next  = ctrl_lsu_adr_i[1] ? 4'b0011 : 4'b1100;
                dat_next   = {2{ctrl_rfb_i[15:0]}};
            end
            2'b10:   misaligned = (ctrl_lsu_adr_i[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Big-endian lane extraction: lane 0 is the most significant byte.
    always_comb begin
        load_data = dbus_dat_i;
        case (len_r)
            2'b00: begin
                load_data[7:0] = dbus_dat_i[8*(3-lsb_r) +: 8];
                load_data[31:8] = zext_r ? 24'h0 : {24{load_data[7]}};
            end
            2'b01: begin
                load_data[15:0] = lsb_r[1] ? dbus_dat_i[15:0] : dbus_dat_i[31:16];
                load_data[31:16] = zext_r ? 16'h0 : {16{load_data[15]}};
            end
            default: load_data = dbus_dat_i;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start && !misaligned) state_next = ACCESS;
            ACCESS: begin
                if (dbus_err_i)            state_next = IDLE;
                else if (dbus_ack_i)       state_next = pipeline_flush_i ? IDLE : DONE;
                else if (pipeline_flush_i) state_next = DRAIN;
            end
            DRAIN:  if (dbus_ack_i || dbus_err_i) state_next = IDLE;
            DONE:   if (padv_ctrl_i || pipeline_flush_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        msync_stall_o = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            dbus_adr_o         <= '0;
            dbus_req_o         <= 1'b0;
            dbus_we_o          <= 1'b0;
            dbus_bsel_o        <= 4'b0000;
            dbus_dat_o         <= '0;
            lsu_result_o       <= '0;
            lsu_valid_o        <= 1'b0;
            lsu_except_align_o <= 1'b0;
            lsu_except_dbus_o  <= 1'b0;
            lsb_r              <= 2'b00;
            len_r              <= 2'b00;
            zext_r             <= 1'b0;
        end else begin
            state       <= state_next;
            dbus_req_o  <= (state_next == ACCESS) || (state_next == DRAIN);
            lsu_valid_o <= (state_next == DONE);
            if (start && !misaligned) begin
                dbus_adr_o  <= {ctrl_lsu_adr_i[OPTION_OPERAND_WIDTH-1:2], 2'b00};
                dbus_we_o   <= ctrl_op_lsu_store_i;
                dbus_bsel_o <= bsel_next;
                dbus_dat_o  <= dat_next;
                lsb_r       <= ctrl_lsu_adr_i[1:0];
                len_r       <= ctrl_lsu_length_i;
                zext_r      <= ctrl_lsu_zext_i;
            end
            if (state == ACCESS && state_next == DONE && !dbus_we_o)
                lsu_result_o <= load_data;
            if (pipeline_flush_i)
                lsu_except_align_o <= 1'b0;
            else if (start && misaligned)
                lsu_except_align_o <= 1'b1;
            if (pipeline_flush_i)
                lsu_except_dbus_o <= 1'b0;
            else if (state == ACCESS && dbus_err_i)
                lsu_except_dbus_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_or1k_ctrl_lsu_cappuccino.sv
// Directed bench for the ctrl-stage LSU: inputs change and outputs are
// checked on the falling edge, the DUT acts on the rising edge.
module tb_or1k_ctrl_lsu_cappuccino;

    logic        clk = 1'b0;
    logic        rst;
    logic        padv_ctrl_i, pipeline_flush_i;
    logic        ctrl_op_lsu_load_i, ctrl_op_lsu_store_i;
    logic [1:0]  ctrl_lsu_length_i;
    logic        ctrl_lsu_zext_i;
    logic [31:0] ctrl_lsu_adr_i, ctrl_rfb_i;
    logic [31:0] dbus_adr_o, dbus_dat_o, dbus_dat_i, lsu_result_o;
    logic        dbus_req_o, dbus_we_o, dbus_ack_i, dbus_err_i;
    logic [3:0]  dbus_bsel_o;
    logic        lsu_valid_o, lsu_except_align_o, lsu_except_dbus_o, msync_stall_o;

    int vectors = 0;
    int miscompares = 0;

    or1k_ctrl_lsu_cappuccino dut (
        .clk(clk), .rst(rst),
        .padv_ctrl_i(padv_ctrl_i), .pipeline_flush_i(pipeline_flush_i),
        .ctrl_op_lsu_load_i(ctrl_op_lsu_load_i), .ctrl_op_lsu_store_i(ctrl_op_lsu_store_i),
        .ctrl_lsu_length_i(ctrl_lsu_length_i), .ctrl_lsu_zext_i(ctrl_lsu_zext_i),
        .ctrl_lsu_adr_i(ctrl_lsu_adr_i), .ctrl_rfb_i(ctrl_rfb_i),
        .dbus_adr_o(dbus_adr_o), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
        .dbus_bsel_o(dbus_bsel_o), .dbus_dat_o(dbus_dat_o),
        .dbus_ack_i(dbus_ack_i), .dbus_err_i(dbus_err_i), .dbus_dat_i(dbus_dat_i),
        .lsu_result_o(lsu_result_o), .lsu_valid_o(lsu_valid_o),
        .lsu_except_align_o(lsu_except_align_o), .lsu_except_dbus_o(lsu_except_dbus_o),
        .msync_stall_o(msync_stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic ld, input logic st, input logic [1:0] len,
                         input logic zx, input logic [31:0] adr, input logic [31:0] rfb);
        ctrl_op_lsu_load_i  = ld;
        ctrl_op_lsu_store_i = st;
        ctrl_lsu_length_i   = len;
        ctrl_lsu_zext_i     = zx;
        ctrl_lsu_adr_i      = adr;
        ctrl_rfb_i          = rfb;
    endtask

    task automatic idle_op();
        ctrl_op_lsu_load_i  = 1'b0;
        ctrl_op_lsu_store_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        padv_ctrl_i = 0; pipeline_flush_i = 0;
        issue(0, 0, 2'b10, 0, 32'h0, 32'h0);
        dbus_ack_i = 0; dbus_err_i = 0; dbus_dat_i = 32'h0;
        tick(); tick();
        chk("rst_req", {31'b0, dbus_req_o}, 32'd0);
        chk("rst_adr", dbus_adr_o, 32'h0);
        chk("rst_dat", dbus_dat_o, 32'h0);
        chk("rst_result", lsu_result_o, 32'h0);
        chk("rst_flags", {27'b0, dbus_we_o, lsu_valid_o, lsu_except_align_o,
                          lsu_except_dbus_o, msync_stall_o}, 32'd0);
        chk("rst_bsel", {28'b0, dbus_bsel_o}, 32'd0);
        rst = 1'b0;
        tick();

        // Word load, zero-wait bus
        issue(1, 0, 2'b10, 0, 32'h100, 32'h0);
        tick();
        idle_op();
        chk("wl_req", {31'b0, dbus_req_o}, 32'd1);
        chk("wl_adr", dbus_adr_o, 32'h100);
        chk("wl_bsel", {28'b0, dbus_bsel_o}, 32'hF);
        chk("wl_we", {31'b0, dbus_we_o}, 32'd0);
        chk("wl_valid_early", {31'b0, lsu_valid_o}, 32'd0);
        chk("wl_stall", {31'b0, msync_stall_o}, 32'd1);
        dbus_ack_i = 1; dbus_dat_i = 32'hDEADBEEF;
        tick();
        dbus_ack_i = 0;
        chk("wl_valid", {31'b0, lsu_valid_o}, 32'd1);
        chk("wl_result", lsu_result_o, 32'hDEADBEEF);
        chk("wl_req_drop", {31'b0, dbus_req_o}, 32'd0);
        tick();
        chk("wl_valid_hold", {31'b0, lsu_valid_o}, 32'd1);
        padv_ctrl_i = 1;
        tick();
        padv_ctrl_i = 0;
        chk("wl_valid_clr", {31'b0, lsu_valid_o}, 32'd0);
        chk("wl_idle", {31'b0, msync_stall_o}, 32'd0);
        tick();
        chk("wl_no_reissue", {31'b0, dbus_req_o}, 32'd0);

        // Byte load sign-extended, lane 3
        issue(1, 0, 2'b00, 0, 32'h203, 32'h0);
        tick();
        idle_op();
        chk("bl_bsel", {28'b0, dbus_bsel_o}, 32'h1);
        chk("bl_adr", dbus_adr_o, 32'h200);
        dbus_ack_i = 1; dbus_dat_i = 32'h123456F0;
        tick();
        dbus_ack_i = 0;
        chk("bl_sext", lsu_result_o, 32'hFFFFFFF0);
        padv_ctrl_i = 1;
        tick();
        padv_ctrl_i = 0;

        // Same byte load zero-extended
        issue(1, 0, 2'b00, 1, 32'h203, 32'h0);
        tick();
        idle_op();
        dbus_ack_i = 1;
        tick();
        dbus_ack_i = 0;
        chk("bl_zext", lsu_result_o, 32'h000000F0);
        padv_ctrl_i = 1;
        tick();
        padv_ctrl_i = 0;

        // Half load sign-extended, upper half
        issue(1, 0, 2'b01, 0, 32'h240, 32'h0);
        tick();
        idle_op();
        chk("hl_bsel", {28'b0, dbus_bsel_o}, 32'hC);
        dbus_ack_i = 1; dbus_dat_i = 32'h8001_7FFF;
        tick();
        dbus_ack_i = 0;
        chk("hl_sext", lsu_result_o, 32'hFFFF8001);
        padv_ctrl_i = 1;
        tick();
        padv_ctrl_i = 0;

        // Half store with one wait cycle
        issue(0, 1, 2'b01, 0, 32'h302, 32'hAAAA1234);
        tick();
        idle_op();
        chk("hs_dat", dbus_dat_o, 32'h12341234);
        chk("hs_bsel", {28'b0, dbus_bsel_o}, 32'h3);
        chk("hs_we", {31'b0, dbus_we_o}, 32'd1);
        chk("hs_adr", dbus_adr_o, 32'h300);
        tick();
        chk("hs_wait_req", {31'b0, dbus_req_o}, 32'd1);
        chk("hs_wait_valid", {31'b0, lsu_valid_o}, 32'd0);
        dbus_ack_i = 1;
        tick();
        dbus_ack_i = 0;
        chk("hs_valid", {31'b0, lsu_valid_o}, 32'd1);
        chk("hs_result_kept", lsu_result_o, 32'hFFFF8001);
        padv_ctrl_i = 1;
        tick();
        padv_ctrl_i = 0;

        // Misaligned word load
        issue(1, 0, 2'b10, 0, 32'h101, 32'h0);
        tick();
        idle_op();
        chk("al_set", {31'b0, lsu_except_align_o}, 32'd1);
        chk("al_no_req", {31'b0, dbus_req_o}, 32'd0);
        chk("al_stall", {31'b0, msync_stall_o}, 32'd0);
        issue(1, 0, 2'b10, 0, 32'h104, 32'h0);
        tick();
        idle_op();
        chk("al_hold", {31'b0, lsu_except_align_o}, 32'd1);
        chk("al_blocks_op", {31'b0, dbus_req_o}, 32'd0);
        pipeline_flush_i = 1;
        tick();
        pipeline_flush_i = 0;
        chk("al_clear", {31'b0, lsu_except_align_o}, 32'd0);

        // Reserved length is always misaligned
        issue(1, 0, 2'b11, 0, 32'h100, 32'h0);
        tick();
        idle_op();
        chk("al_len11", {31'b0, lsu_except_align_o}, 32'd1);
        pipeline_flush_i = 1;
        tick();
        pipeline_flush_i = 0;

        // Bus error with simultaneous ack after 3 wait cycles
        issue(1, 0, 2'b10, 0, 32'h400, 32'h0);
        tick();
        idle_op();
        tick(); tick(); tick();
        chk("be_req_wait", {31'b0, dbus_req_o}, 32'd1);
        dbus_err_i = 1; dbus_ack_i = 1; dbus_dat_i = 32'h55555555;
        tick();
        dbus_err_i = 0; dbus_ack_i = 0;
        chk("be_flag", {31'b0, lsu_except_dbus_o}, 32'd1);
        chk("be_no_valid", {31'b0, lsu_valid_o}, 32'd0);
        chk("be_req_drop", {31'b0, dbus_req_o}, 32'd0);
        chk("be_result_kept", lsu_result_o, 32'hFFFF8001);
        tick();
        chk("be_hold", {31'b0, lsu_except_dbus_o}, 32'd1);
        pipeline_flush_i = 1;
        tick();
        pipeline_flush_i = 0;
        chk("be_clear", {31'b0, lsu_except_dbus_o}, 32'd0);

        // Flush during access, ack arrives 4 cycles later
        issue(1, 0, 2'b10, 0, 32'h500, 32'h0);
        tick();
        idle_op();
        pipeline_flush_i = 1;
        tick();
        pipeline_flush_i = 0;
        chk("fl_req_held", {31'b0, dbus_req_o}, 32'd1);
        tick(); tick();
        chk("fl_stall", {31'b0, msync_stall_o}, 32'd1);
        chk("fl_req_held2", {31'b0, dbus_req_o}, 32'd1);
        dbus_ack_i = 1; dbus_dat_i = 32'h0BADF00D;
        tick();
        dbus_ack_i = 0;
        chk("fl_req_drop", {31'b0, dbus_req_o}, 32'd0);
        chk("fl_no_valid", {31'b0, lsu_valid_o}, 32'd0);
        chk("fl_result_kept", lsu_result_o, 32'hFFFF8001);
        chk("fl_idle", {31'b0, msync_stall_o}, 32'd0);
        chk("fl_no_exc", {30'b0, lsu_except_align_o, lsu_except_dbus_o}, 32'd0);

        // Byte store lane 1, then async reset mid-access
        issue(0, 1, 2'b00, 0, 32'h601, 32'h000000A5);
        tick();
        idle_op();
        chk("bs_dat", dbus_dat_o, 32'hA5A5A5A5);
        chk("bs_bsel", {28'b0, dbus_bsel_o}, 32'h4);
        #1 rst = 1'b1;
        #1;
        chk("rm_req", {31'b0, dbus_req_o}, 32'd0);
        chk("rm_stall", {31'b0, msync_stall_o}, 32'd0);
        chk("rm_adr", dbus_adr_o, 32'h0);
        chk("rm_result", lsu_result_o, 32'h0);
        tick();
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
